// File: rtl/pc_stack_pkg.sv
// Shared types and constants for the program-counter / return-address stack stage.
// Holds default sizes, the decoder strobe bundle and its legal encodings.
package pc_stack_pkg;

    localparam int DEF_PC_WIDTH    = 5;
    localparam int DEF_STACK_DEPTH = 8;

    typedef logic [DEF_PC_WIDTH-1:0] pc_t;

    typedef struct packed {
        logic push;
        logic pop;
        logic jmp;
        logic cal;
        logic ret;
    } ctrl_s;

    localparam ctrl_s CTRL_NONE = 5'b00000;
    localparam ctrl_s CTRL_JMP  = 5'b00100;
    localparam ctrl_s CTRL_CAL  = 5'b10110;
    localparam ctrl_s CTRL_RET  = 5'b01001;

    function automatic logic is_legal(input ctrl_s c);
        return (c == CTRL_NONE) || (c == CTRL_JMP) || (c == CTRL_CAL) || (c == CTRL_RET);
    endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Decoder-to-PC-stage bundle: control strobes and jump target in, pc and stack status out.
interface pc_call_stack_if
    import pc_stack_pkg::*;
#(
    parameter int PC_WIDTH = DEF_PC_WIDTH,
    parameter int SP_WIDTH = $clog2(DEF_STACK_DEPTH) + 1
);
    logic                en;
    logic                push;
    logic                pop;
    logic                jmp;
    logic                cal;
    logic                ret;
    logic [PC_WIDTH-1:0] jmp_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [SP_WIDTH-1:0] sp;
    logic                stk_ovf;
    logic                stk_unf;
    logic                proto_err;

    modport master (
        output en, push, pop, jmp, cal, ret, jmp_addr,
        input  pc, sp, stk_ovf, stk_unf, proto_err
    );

    modport slave (
        input  en, push, pop, jmp, cal, ret, jmp_addr,
        output pc, sp, stk_ovf, stk_unf, proto_err
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Return-address LIFO: register array, stack pointer and full/empty detection.
// PC_STACK_GUARD_EN blocks push-when-full / pop-when-empty and raises sticky flags.
module ret_addr_stack
    import pc_stack_pkg::*;
#(
    parameter  int PC_WIDTH    = DEF_PC_WIDTH,
    parameter  int STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                push,
    input  logic                pop,
    input  logic                rd,
    input  logic [PC_WIDTH-1:0] wr_data,
    output logic [PC_WIDTH-1:0] rd_data,
    output logic [SP_WIDTH-1:0] sp,
    output logic                push_block,
    output logic                pop_block,
    output logic                stk_ovf,
    output logic                stk_unf
);

    localparam int IDX_WIDTH = $clog2(STACK_DEPTH);

    logic [PC_WIDTH-1:0]  mem [STACK_DEPTH];
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [IDX_WIDTH-1:0] rd_idx;
    logic                 full;
    logic                 empty;

    // Index is sp modulo depth, so an unguarded overflow overwrites the oldest entry.
    assign full    = (sp == SP_WIDTH'(STACK_DEPTH));
    assign empty   = (sp == '0);
    assign wr_idx  = sp[IDX_WIDTH-1:0];
    assign rd_idx  = wr_idx - IDX_WIDTH'(1);
    assign rd_data = rd ? mem[rd_idx] : '0;

`ifdef PC_STACK_GUARD_EN
    assign push_block = push & full;
    assign pop_block  = (pop | rd) & empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (en) begin
            stk_ovf <= stk_ovf | push_block;
            stk_unf <= stk_unf | pop_block;
        end
    end
`else
    assign push_block = 1'b0;
    assign pop_block  = 1'b0;
    assign stk_ovf    = 1'b0;
    assign stk_unf    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (en) begin
            if (push && !push_block) begin
                if (!full) sp <= sp + SP_WIDTH'(1);
            end else if (pop && !pop_block && !empty) begin
                sp <= sp - SP_WIDTH'(1);
            end
        end
    end

    // Contents need no reset; only entries below sp are ever meaningful.
    always_ff @(posedge clk) begin
        if (en && push && !push_block) mem[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program-counter stage: pc register, next-PC select (ret > jmp > pc+1) and strobe protocol check.
// Build with PC_STACK_GUARD_EN to enable stack overflow/underflow protection.
module pc_call_stack
    import pc_stack_pkg::*;
#(
    parameter  int PC_WIDTH    = DEF_PC_WIDTH,
    parameter  int STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int SP_WIDTH    = $clog2(STACK_DEPTH) + 1
)(
    input logic             clk,
    input logic             rst_n,
    pc_call_stack_if.slave  bus
);

    ctrl_s               ctrl;
    logic                bad_combo;
    logic                s_push;
    logic                s_pop;
    logic                s_jmp;
    logic                s_ret;
    logic                push_block;
    logic                pop_block;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] top_addr;
    logic [SP_WIDTH-1:0] sp;
    logic                stk_ovf;
    logic                stk_unf;
    logic                proto_err_q;

    assign ctrl = {bus.push, bus.pop, bus.jmp, bus.cal, bus.ret};

    // Contradictory pairs cancel every stack op and redirect; the rest run literally.
    assign bad_combo = (ctrl.push & ctrl.pop) | (ctrl.ret & ctrl.jmp);
    assign s_push    = ctrl.push & ~bad_combo;
    assign s_pop     = ctrl.pop  & ~bad_combo;
    assign s_jmp     = ctrl.jmp  & ~bad_combo;
    assign s_ret     = ctrl.ret  & ~bad_combo;
    assign pc_inc    = pc_q + PC_WIDTH'(1);

    always_comb begin
        pc_next = pc_inc;
        if (push_block || pop_block) pc_next = pc_inc;
        else if (s_ret)              pc_next = top_addr;
        else if (s_jmp)              pc_next = bus.jmp_addr;
    end

    ret_addr_stack #(
        .PC_WIDTH    (PC_WIDTH),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (bus.en),
        .push       (s_push),
        .pop        (s_pop),
        .rd         (s_ret),
        .wr_data    (pc_inc),
        .rd_data    (top_addr),
        .sp         (sp),
        .push_block (push_block),
        .pop_block  (pop_block),
        .stk_ovf    (stk_ovf),
        .stk_unf    (stk_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= '0;
            proto_err_q <= 1'b0;
        end else if (bus.en) begin
            pc_q <= pc_next;
            if (!is_legal(ctrl)) proto_err_q <= 1'b1;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.sp        = sp;
    assign bus.stk_ovf   = stk_ovf;
    assign bus.stk_unf   = stk_unf;
    assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: reference model feeds an expectation queue checked each cycle.
// Boundary expectations follow PC_STACK_GUARD_EN when the bench is built with it.
module tb_pc_call_stack;
    import pc_stack_pkg::*;

    localparam int PW    = DEF_PC_WIDTH;
    localparam int DEPTH = DEF_STACK_DEPTH;
    localparam int SPW   = $clog2(DEPTH) + 1;

    typedef struct packed {
        pc_t            pc;
        logic [SPW-1:0] sp;
        logic           ovf;
        logic           unf;
        logic           perr;
    } exp_s;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    exp_s exp_q[$];

    pc_t  m_pc;
    int   m_sp;
    pc_t  m_stk [DEPTH];
    bit   m_ovf, m_unf, m_perr;

    always #5 clk = ~clk;

    pc_call_stack_if #(.PC_WIDTH(PW), .SP_WIDTH(SPW)) bus ();

    pc_call_stack #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic void model_step(input bit r, input bit e, input ctrl_s c, input pc_t a);
        pc_t npc;
        pc_t inc;
        bit  bad;
        if (!r) begin
            m_pc = '0; m_sp = 0; m_ovf = 0; m_unf = 0; m_perr = 0;
            return;
        end
        if (!e) return;
        inc = m_pc + pc_t'(1);
        npc = inc;
        bad = (c.push && c.pop) || (c.ret && c.jmp);
        if (!(c == CTRL_NONE || c == CTRL_JMP || c == CTRL_CAL || c == CTRL_RET)) m_perr = 1;
        if (!bad) begin
`ifdef PC_STACK_GUARD_EN
            if (c.push && m_sp == DEPTH) m_ovf = 1;
            else if ((c.pop || c.ret) && m_sp == 0) m_unf = 1;
            else
`endif
            begin
                if (c.ret)      npc = m_stk[(m_sp + DEPTH - 1) % DEPTH];
                else if (c.jmp) npc = a;
                if (c.push) begin
                    m_stk[m_sp % DEPTH] = inc;
                    if (m_sp < DEPTH) m_sp++;
                end else if (c.pop && m_sp > 0) begin
                    m_sp--;
                end
            end
        end
        m_pc = npc;
    endfunction

    task automatic check_output();
        exp_s x;
        x = exp_q.pop_front();
        checks += 5;
        assert (bus.pc === x.pc) else begin
            failures++; $error("[TB] FAIL pc: observed=%0d expected=%0d", bus.pc, x.pc);
        end
        assert (bus.sp === x.sp) else begin
            failures++; $error("[TB] FAIL sp: observed=%0d expected=%0d", bus.sp, x.sp);
        end
        assert (bus.stk_ovf === x.ovf) else begin
            failures++; $error("[TB] FAIL stk_ovf: observed=%b expected=%b", bus.stk_ovf, x.ovf);
        end
        assert (bus.stk_unf === x.unf) else begin
            failures++; $error("[TB] FAIL stk_unf: observed=%b expected=%b", bus.stk_unf, x.unf);
        end
        assert (bus.proto_err === x.perr) else begin
            failures++; $error("[TB] FAIL proto_err: observed=%b expected=%b", bus.proto_err, x.perr);
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit e, input ctrl_s c, input pc_t a);
        exp_s x;
        rst_n        = r;
        bus.en       = e;
        bus.push     = c.push;
        bus.pop      = c.pop;
        bus.jmp      = c.jmp;
        bus.cal      = c.cal;
        bus.ret      = c.ret;
        bus.jmp_addr = a;
        model_step(r, e, c, a);
        x.pc   = m_pc;
        x.sp   = SPW'(m_sp);
        x.ovf  = m_ovf;
        x.unf  = m_unf;
        x.perr = m_perr;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++; $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1, CTRL_NONE, '0);
    endtask

    task automatic run_to(input pc_t target);
        int guard_cnt;
        guard_cnt = 0;
        while (m_pc != target && guard_cnt < 40) begin
            idle(1);
            guard_cnt++;
        end
        checks++;
        assert (m_pc == target) else begin
            failures++; $error("[TB] FAIL run_to: observed=%0d expected=%0d", m_pc, target);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.jmp      = 1'b0;
        bus.cal      = 1'b0;
        bus.ret      = 1'b0;
        bus.jmp_addr = '0;

        apply_stimulus(1'b0, 1'b1, CTRL_NONE, '0);
        check_value("reset_pc", bus.pc, 0);

        idle(4);
        check_value("count_pc", bus.pc, 4);
        apply_stimulus(1'b1, 1'b0, CTRL_CAL, 5'd9);
        apply_stimulus(1'b1, 1'b0, CTRL_CAL, 5'd9);
        check_value("stall_pc", bus.pc, 4);
        check_value("stall_sp", bus.sp, 0);

        run_to(5'd31);
        idle(1);
        check_value("wrap_pc", bus.pc, 0);

        run_to(5'd3);
        apply_stimulus(1'b1, 1'b1, CTRL_CAL, 5'd20);
        check_value("call_pc", bus.pc, 20);
        check_value("call_sp", bus.sp, 1);
        idle(2);
        apply_stimulus(1'b1, 1'b1, CTRL_RET, '0);
        check_value("ret_pc", bus.pc, 4);
        check_value("ret_sp", bus.sp, 0);

        run_to(5'd2);
        apply_stimulus(1'b1, 1'b1, CTRL_CAL, 5'd10);
        idle(1);
        apply_stimulus(1'b1, 1'b1, CTRL_CAL, 5'd20);
        check_value("nest_sp", bus.sp, 2);
        apply_stimulus(1'b1, 1'b1, CTRL_RET, '0);
        check_value("nest_ret1_pc", bus.pc, 12);
        apply_stimulus(1'b1, 1'b1, CTRL_RET, '0);
        check_value("nest_ret2_pc", bus.pc, 3);
        check_value("nest_ret2_sp", bus.sp, 0);

        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 1'b1, CTRL_CAL, pc_t'(10 + 2 * i));
        check_value("full_sp", bus.sp, 8);
`ifdef PC_STACK_GUARD_EN
        check_value("full_pc", bus.pc, 25);
        check_value("full_ovf", bus.stk_ovf, 1);
`else
        check_value("full_pc", bus.pc, 26);
        check_value("full_ovf", bus.stk_ovf, 0);
`endif
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, CTRL_RET, '0);
        apply_stimulus(1'b1, 1'b1, CTRL_RET, '0);
        check_value("empty_sp", bus.sp, 0);
`ifdef PC_STACK_GUARD_EN
        check_value("empty_pc", bus.pc, 5);
        check_value("empty_unf", bus.stk_unf, 1);
`else
        check_value("empty_pc", bus.pc, 23);
        check_value("empty_unf", bus.stk_unf, 0);
`endif

        apply_stimulus(1'b1, 1'b1, CTRL_CAL, 5'd7);
        apply_stimulus(1'b1, 1'b1, CTRL_CAL, 5'd9);
        apply_stimulus(1'b1, 1'b1, 5'b11000, 5'd17);
        check_value("pushpop_sp", bus.sp, 2);
        check_value("pushpop_pc", bus.pc, 10);
        check_value("pushpop_perr", bus.proto_err, 1);

        apply_stimulus(1'b0, 1'b1, CTRL_CAL, 5'd3);
        check_value("rst2_pc", bus.pc, 0);
        check_value("rst2_sp", bus.sp, 0);
        check_value("rst2_flags", {bus.stk_ovf, bus.stk_unf, bus.proto_err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
